// File: rtl/mdu_pkg.sv
// Shared constants and state encoding for the multiply/divide unit.
// MDU_FAST_MULT_EN removes the iterative MUL state (multiply becomes single-cycle).
package mdu_pkg;

   localparam int unsigned ITER_COUNT = 32;
   localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

   localparam logic [3:0] OP_NONE  = 4'b0000;
   localparam logic [3:0] OP_MULT  = 4'b0001;
   localparam logic [3:0] OP_MULTU = 4'b0010;
   localparam logic [3:0] OP_DIV   = 4'b0011;
   localparam logic [3:0] OP_DIVU  = 4'b0100;
   localparam logic [3:0] OP_MTHI  = 4'b0101;
   localparam logic [3:0] OP_MTLO  = 4'b0110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
`ifndef MDU_FAST_MULT_EN
      S_MUL  = 2'd1,
`endif
      S_DIV  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per step.
// The step results are exposed combinationally so the caller can capture the final bit.
module mdu_divider
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        step_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] quo_step_o,
   output logic [31:0] rem_step_o
);

   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvsr_q, dvsr_d;
   logic [32:0] shifted;
   logic [32:0] diff;

   // Dividend bits shift out of quo_q into the remainder as quotient bits shift in.
   always_comb begin
      shifted    = {rem_q, quo_q[31]};
      diff       = shifted - {1'b0, dvsr_q};
      quo_step_o = {quo_q[30:0], ~diff[32]};
      rem_step_o = diff[32] ? shifted[31:0] : diff[31:0];
   end

   always_comb begin
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvsr_d = dvsr_q;
      if (load_i) begin
         quo_d  = dividend_i;
         rem_d  = '0;
         dvsr_d = divisor_i;
      end else if (step_i) begin
         quo_d = quo_step_o;
         rem_d = rem_step_o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dvsr_q <= '0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvsr_q <= dvsr_d;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit: shift-add multiplier, sign fix-up and sequencing FSM.
// Define MDU_FAST_MULT_EN for a single-cycle multiplier (no MUL state).
//
// state  | meaning
// S_IDLE | accepting start; mthi/mtlo/div-by-zero/fast-mult complete here
// S_MUL  | shift-add multiply iterations (absent with MDU_FAST_MULT_EN)
// S_DIV  | restoring divide iterations
module mul_div_unit
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  mdOp,
   input  logic        start,
   input  logic        flush,
   input  logic [31:0] din1,
   input  logic [31:0] din2,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;

   logic             is_signed;
   logic [31:0]      a_abs, b_abs;
   logic             div_load, div_step;
   logic [31:0]      quo_step, rem_step;

`ifdef MDU_FAST_MULT_EN
   logic [63:0]      fast_prod;
`else
   logic [31:0]      mcand_q, mcand_d;
   logic [63:0]      prod_q, prod_d, prod_step, mul_res;
   logic [32:0]      mul_sum;
`endif

   always_comb begin
      is_signed = (mdOp == OP_MULT) || (mdOp == OP_DIV);
      a_abs     = (is_signed && din1[31]) ? -din1 : din1;
      b_abs     = (is_signed && din2[31]) ? -din2 : din2;
   end

`ifdef MDU_FAST_MULT_EN
   always_comb begin
      fast_prod = {32'h0, a_abs} * {32'h0, b_abs};
      if (is_signed && (din1[31] ^ din2[31]))
         fast_prod = -fast_prod;
   end
`else
   // Low half of prod_q holds the unconsumed multiplier bits.
   always_comb begin
      mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
      prod_step = {mul_sum, prod_q[31:1]};
      mul_res   = neg_res_q ? -prod_step : prod_step;
   end
`endif

   mdu_divider u_div (
      .clk        (clk),
      .rst        (rst),
      .load_i     (div_load),
      .step_i     (div_step),
      .dividend_i (a_abs),
      .divisor_i  (b_abs),
      .quo_step_o (quo_step),
      .rem_step_o (rem_step)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div_load  = 1'b0;
      div_step  = 1'b0;
`ifndef MDU_FAST_MULT_EN
      mcand_d   = mcand_q;
      prod_d    = prod_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               case (mdOp)
                  OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MULT_EN
                     {hi_d, lo_d} = fast_prod;
`else
                     state_d   = S_MUL;
                     cnt_d     = CNT_W'(ITER_COUNT - 1);
                     mcand_d   = a_abs;
                     prod_d    = {32'h0, b_abs};
                     neg_res_d = is_signed && (din1[31] ^ din2[31]);
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     if (din2 == 32'h0) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = din1;
                     end else begin
                        state_d   = S_DIV;
                        cnt_d     = CNT_W'(ITER_COUNT - 1);
                        div_load  = 1'b1;
                        neg_res_d = is_signed && (din1[31] ^ din2[31]);
                        neg_rem_d = is_signed && din1[31];
                     end
                  end
                  OP_MTHI: hi_d = din1;
                  OP_MTLO: lo_d = din1;
                  default: ;
               endcase
            end
         end
`ifndef MDU_FAST_MULT_EN
         S_MUL: begin
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               prod_d = prod_step;
               if (cnt_q == '0) begin
                  state_d      = S_IDLE;
                  {hi_d, lo_d} = mul_res;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
`endif
         S_DIV: begin
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               div_step = 1'b1;
               if (cnt_q == '0) begin
                  state_d = S_IDLE;
                  lo_d    = neg_res_q ? -quo_step : quo_step;
                  hi_d    = neg_rem_q ? -rem_step : rem_step;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
      end
   end

`ifndef MDU_FAST_MULT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q <= '0;
         prod_q  <= '0;
      end else begin
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
      end
   end
`endif

   assign busy = (state_q != S_IDLE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL use one clock, `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Port list, clock and reset first:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `mdOp` in 4: operation select.
- `start` in 1: issue strobe for `mdOp`.
- `flush` in 1: abort the in-flight operation.
- `din1` in 32: rs operand / dividend.
- `din2` in 32: rt operand / divisor.
- `busy` out 1: operation in progress; the pipeline stalls while it is high.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
REQ-003 `mdOp` encodings SHALL be:
- 4'b0000 none
- 4'b0001 mult
- 4'b0010 multu
- 4'b0011 div
- 4'b0100 divu
- 4'b0101 mthi
- 4'b0110 mtlo

Function
REQ-004 The state machine SHALL have three states, IDLE, MUL and DIV:
- IDLE -> MUL when `start` is high with mult/multu.
- IDLE -> DIV when `start` is high with div/divu and `din2` is non-zero.
- MUL/DIV -> IDLE after 32 iterations, or on `flush`.
REQ-005 `start` SHALL be sampled only in IDLE; `start` while `busy`=1 SHALL be ignored.
REQ-006 Iterative ops, `start` sampled at edge k:
- `busy`=1 for cycles k+1..k+32.
- `hi`/`lo` SHALL update at edge k+32 and be valid with `busy`=0 from cycle k+33.
REQ-007 `hi`/`lo` SHALL hold their previous values throughout an iterative op.
REQ-008 mthi/mtlo SHALL write `din1` to `hi`/`lo` at the sampling edge, without asserting `busy`.
REQ-009 mult/multu SHALL form the full 64-bit product, signed or unsigned, with {`hi`,`lo`} = product.
REQ-010 The iterative multiply SHALL be shift-add, one bit per cycle.
REQ-011 div/divu SHALL place the quotient in `lo` and the remainder in `hi`; divide is restoring, one quotient bit per cycle.
REQ-012 Signed div SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-013 Signed div 0x80000000 / 0xFFFFFFFF SHALL give `lo`=0x80000000 and `hi`=0, with no exception.
REQ-014 Divisor zero (div or divu) SHALL complete at the sampling edge with `lo`=0xFFFFFFFF and `hi`=`din1`; `busy` SHALL never assert.
REQ-015 `flush` SHALL take priority over everything except `rst`:
- In MUL/DIV: return to IDLE at the next edge, `busy`=0 the cycle after, `hi`/`lo` unchanged, partial result discarded.
- In IDLE: suppress a same-cycle `start`.
REQ-016 `start` and the last iteration cycle coinciding SHALL NOT launch a new op, because `busy` is still 1.
REQ-017 Operands SHALL be latched at the start edge; `din1`/`din2` changes during `busy` SHALL have no effect.

Reset
REQ-018 `rst`=1 at an edge SHALL force IDLE, `busy`=0, `hi`=0, `lo`=0 and the iteration counter to 0, including mid-operation.
REQ-019 `rst` SHALL override `start` and `flush` in the same cycle.

Configuration
REQ-020 With `MDU_FAST_MULT_EN` defined:
- mult/multu SHALL complete single-cycle, writing `hi`/`lo` at the sampling edge.
- `busy` SHALL never assert for multiply; the MUL state is absent.
REQ-021 Without `MDU_FAST_MULT_EN`, multiply SHALL take 32 cycles per REQ-006.
REQ-022 Divide timing SHALL be identical with or without the macro.

Structure
REQ-023 Package `mdu_pkg` SHALL hold:
- the `mdOp` encoding constants;
- the FSM state typedef;
- ITER_COUNT=32.
REQ-024 Sub-module `mdu_divider` SHALL implement the iterative unsigned restoring divider.
REQ-025 Sign fix-up and the multiplier SHALL live in mul_div_unit.

Verification
REQ-026 multu 0xFFFFFFFF×0xFFFFFFFF -> 32 `busy` cycles, then `hi`=0xFFFFFFFE, `lo`=0x00000001; with `MDU_FAST_MULT_EN`, same values next cycle and `busy` never high.
REQ-027 mult 0xFFFFFFFB(-5)×3 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
REQ-028 div -7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; divu 0xFFFFFFFF/0x10 -> `lo`=0x0FFFFFFF, `hi`=0xF.
REQ-029 divu 5/0 -> next cycle `lo`=0xFFFFFFFF, `hi`=5, `busy` never high; div 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
REQ-030 Control interruptions:
- mthi 0x1234 then mtlo 0xABCD -> `hi`=0x1234, `lo`=0xABCD.
- `flush` at busy cycle 10 of a div -> `busy`=0 next cycle, `hi`/`lo` unchanged.
- `rst` at busy cycle 5 -> all outputs 0.
REQ-031 `start` while `busy` -> ignored, first result intact; `start` on the first idle cycle -> accepted.
